// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM with a fixed access latency and a busy stall to the pipeline.
// Optional sub-word loads/stores are enabled by defining DMEM_SUBWORD_EN.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2     // legal range 1..15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        mem_op,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_data_in,
`ifdef DMEM_SUBWORD_EN
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
`endif
    output logic        busy,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        misalign_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic                  w_capture;
    logic                  w_access;

    logic                  r_op;
    logic [DEPTH_LOG2+1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [DEPTH_LOG2-1:0] w_idx;

    logic                  w_misalign;
    logic                  w_load_ok;
    logic [3:0]            w_be;
    logic [3:0]            w_we;
    logic [31:0]           w_wdata_lane;
    logic [31:0]           w_rd_word;

    logic                  r_rdata_valid;
    logic                  r_misalign_err;

    // Address bits above the RAM index alias onto the same words by design.
    logic                  w_unused_addr_hi;
    assign w_unused_addr_hi = ^mem_address[31:DEPTH_LOG2+2];

    assign w_capture = (r_state == ST_IDLE) && req_valid;
    assign w_access  = (r_state == ST_WAIT) && (r_cnt == 4'd0) && !reset;
    assign w_idx     = r_addr[DEPTH_LOG2+1:2];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    busy         = 1'b1;
                    w_state_next = ST_WAIT;
                    w_cnt_next   = 4'(LATENCY - 1);
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_op    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_capture) begin
            r_op    <= mem_op;
            r_addr  <= mem_address[DEPTH_LOG2+1:0];
            r_wdata <= mem_data_in;
        end
    end

`ifdef DMEM_SUBWORD_EN
    logic       r_size_byte;
    logic       r_size_half;
    logic       r_signed;
    logic [1:0] r_out_off;
    logic       r_out_byte;
    logic       r_out_half;
    logic       r_out_signed;
    logic [7:0] w_rd_byte;
    logic [15:0] w_rd_half;

    // Size 11 decodes as word: only the two sub-word encodings are special.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_size_byte <= 1'b0;
            r_size_half <= 1'b0;
            r_signed    <= 1'b0;
        end else if (w_capture) begin
            r_size_byte <= (mem_size == 2'b00);
            r_size_half <= (mem_size == 2'b01);
            r_signed    <= mem_signed;
        end
    end

    always_comb begin
        w_misalign   = (r_addr[1:0] != 2'b00);
        w_be         = 4'b1111;
        w_wdata_lane = r_wdata;
        if (r_size_byte) begin
            w_misalign   = 1'b0;
            w_be         = 4'b0001 << r_addr[1:0];
            w_wdata_lane = {4{r_wdata[7:0]}};
        end else if (r_size_half) begin
            w_misalign   = r_addr[0];
            w_be         = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata_lane = {2{r_wdata[15:0]}};
        end
    end

    // Lane selection is frozen with the read word so rdata holds until the next response.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_off    <= 2'b00;
            r_out_byte   <= 1'b0;
            r_out_half   <= 1'b0;
            r_out_signed <= 1'b0;
        end else if (w_access) begin
            r_out_off    <= r_addr[1:0];
            r_out_byte   <= r_size_byte;
            r_out_half   <= r_size_half;
            r_out_signed <= r_signed;
        end
    end

    assign w_rd_byte = 8'(w_rd_word >> {r_out_off, 3'b000});
    assign w_rd_half = r_out_off[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    always_comb begin
        rdata = w_rd_word;
        if (r_out_byte) begin
            rdata = {{24{r_out_signed & w_rd_byte[7]}}, w_rd_byte};
        end else if (r_out_half) begin
            rdata = {{16{r_out_signed & w_rd_half[15]}}, w_rd_half};
        end
    end
`else
    assign w_misalign   = (r_addr[1:0] != 2'b00);
    assign w_be         = 4'b1111;
    assign w_wdata_lane = r_wdata;
    assign rdata        = w_rd_word;
`endif

    assign w_load_ok = !r_op && !w_misalign;

    // One byte-wide RAM per lane so partial stores need no read-modify-write.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_lane_mem [0:DEPTH-1];
            logic [7:0] r_lane_rd;

            assign w_we[gi] = w_access && r_op && !w_misalign && w_be[gi];

            always_ff @(posedge clock) begin
                if (w_we[gi]) begin
                    r_lane_mem[w_idx] <= w_wdata_lane[gi*8 +: 8];
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_lane_rd <= 8'h00;
                end else if (w_access) begin
                    r_lane_rd <= w_load_ok ? r_lane_mem[w_idx] : 8'h00;
                end
            end

            assign w_rd_word[gi*8 +: 8] = r_lane_rd;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata_valid  <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            r_rdata_valid  <= w_access;
            r_misalign_err <= w_access && w_misalign;
        end
    end

    assign rdata_valid  = r_rdata_valid;
    assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: requests push expected responses to a scoreboard,
// popped and compared when rdata_valid fires.
module tb_dmem_responder;

    localparam int LATENCY    = 2;
    localparam int DEPTH_LOG2 = 10;
    localparam int PERIOD     = 10;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        mem_op;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
`ifdef DMEM_SUBWORD_EN
    logic [1:0]  mem_size;
    logic        mem_signed;
`endif
    logic        busy;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misalign_err;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        err;
    } sb_entry_t;

    sb_entry_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    dmem_responder #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .LATENCY    (LATENCY)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .mem_op       (mem_op),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
`ifdef DMEM_SUBWORD_EN
        .mem_size     (mem_size),
        .mem_signed   (mem_signed),
`endif
        .busy         (busy),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .misalign_err (misalign_err)
    );

    initial clock = 1'b0;
    always #(PERIOD/2) clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns one cycle after the response.
    task automatic do_req(input string tag, input logic op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [1:0] size, input logic sgn,
                          input logic [31:0] exp_rd, input logic exp_err, input logic keep,
                          output time t_done);
        int        busy_cyc;
        int        waited;
        sb_entry_t e;
        sb.push_back('{tag: tag, rd: exp_rd, err: exp_err});
        req_valid   = 1'b1;
        mem_op      = op;
        mem_address = addr;
        mem_data_in = data;
`ifdef DMEM_SUBWORD_EN
        mem_size    = size;
        mem_signed  = sgn;
`endif
        busy_cyc = 0;
        waited   = 0;
        #1;
        while (rdata_valid !== 1'b1 && waited < 40) begin
            if (busy === 1'b1) busy_cyc++;
            @(negedge clock);
            waited++;
        end
        t_done = $time;
        e = sb.pop_front();
        check({e.tag, "_latency"}, 32'(waited), 32'(LATENCY + 1));
        check({e.tag, "_busy_cycles"}, 32'(busy_cyc), 32'(LATENCY + 1));
        check({e.tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check({e.tag, "_rdata"}, rdata, e.rd);
        check({e.tag, "_misalign"}, 32'(misalign_err), 32'(e.err));
        $display("txn %s op=%0d addr=%h data=%h size=%0d sgn=%0d rdata=%h err=%0d t=%0t",
                 e.tag, op, addr, data, size, sgn, rdata, misalign_err, t_done);
        req_valid = keep;
        @(negedge clock);
        check({e.tag, "_valid_pulse"}, 32'(rdata_valid), 32'd0);
        check({e.tag, "_err_pulse"}, 32'(misalign_err), 32'd0);
        check({e.tag, "_rdata_hold"}, rdata, e.rd);
    endtask

    time t1, t2, t3, t_x;

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        mem_op      = 1'b0;
        mem_address = 32'h0;
        mem_data_in = 32'h0;
`ifdef DMEM_SUBWORD_EN
        mem_size    = 2'b10;
        mem_signed  = 1'b0;
`endif
        repeat (3) @(negedge clock);
        check("reset_rdata", rdata, 32'h0);
        check("reset_valid", 32'(rdata_valid), 32'd0);
        check("reset_misalign", 32'(misalign_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_busy", 32'(busy), 32'd0);

        do_req("st_100",     1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0, 1'b0, t_x);
        do_req("ld_100",     1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, t_x);
        do_req("ld_103_mis", 1'b0, 32'h103, 32'h0,        2'b10, 1'b0, 32'h0,        1'b1, 1'b0, t_x);
        do_req("ld_100_b",   1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, t_x);
        do_req("st_102_mis", 1'b1, 32'h102, 32'h00000BAD, 2'b10, 1'b0, 32'h0,        1'b1, 1'b0, t_x);
        do_req("ld_100_c",   1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, t_x);
        do_req("st_200",     1'b1, 32'h200, 32'h11111111, 2'b10, 1'b0, 32'h0,        1'b0, 1'b0, t_x);

        // Back-to-back with req_valid never dropping between requests.
        do_req("b2b_ld_100", 1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, t1);
        do_req("b2b_ld_200", 1'b0, 32'h200, 32'h0,        2'b10, 1'b0, 32'h11111111, 1'b0, 1'b1, t2);
        do_req("b2b_st_300", 1'b1, 32'h300, 32'h55AA55AA, 2'b10, 1'b0, 32'h0,        1'b0, 1'b0, t3);
        check("b2b_gap_1_2", 32'(t2 - t1), 32'((LATENCY + 2) * PERIOD));
        check("b2b_gap_2_3", 32'(t3 - t2), 32'((LATENCY + 2) * PERIOD));
        do_req("ld_300",     1'b0, 32'h300, 32'h0,        2'b10, 1'b0, 32'h55AA55AA, 1'b0, 1'b0, t_x);

        do_req("st_alias",   1'b1, 32'h1000, 32'h12345678, 2'b10, 1'b0, 32'h0,       1'b0, 1'b0, t_x);
        do_req("ld_alias",   1'b0, 32'h0000, 32'h0,        2'b10, 1'b0, 32'h12345678, 1'b0, 1'b0, t_x);

        // Reset lands on the commit edge of a store; it must win.
        do_req("ld_pre_rst", 1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, t_x);
        req_valid   = 1'b1;
        mem_op      = 1'b1;
        mem_address = 32'h200;
        mem_data_in = 32'hCAFEF00D;
`ifdef DMEM_SUBWORD_EN
        mem_size    = 2'b10;
`endif
        @(negedge clock);
        @(negedge clock);
        check("abort_busy_wait", 32'(busy), 32'd1);
        reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge clock);
        check("abort_rdata", rdata, 32'h0);
        check("abort_valid", 32'(rdata_valid), 32'd0);
        check("abort_misalign", 32'(misalign_err), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        $display("txn abort_st_200 reset in WAIT rdata=%h valid=%0d", rdata, rdata_valid);
        reset = 1'b0;
        @(negedge clock);
        do_req("ld_200_post", 1'b0, 32'h200, 32'h0,       2'b10, 1'b0, 32'h11111111, 1'b0, 1'b0, t_x);

`ifdef DMEM_SUBWORD_EN
        do_req("sw_st_40",    1'b1, 32'h40, 32'h80FF7F01, 2'b10, 1'b0, 32'h0,        1'b0, 1'b0, t_x);
        do_req("sw_lb_42_s",  1'b0, 32'h42, 32'h0,        2'b00, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, t_x);
        do_req("sw_lh_42_u",  1'b0, 32'h42, 32'h0,        2'b01, 1'b0, 32'h000080FF, 1'b0, 1'b0, t_x);
        do_req("sw_lh_41_mis",1'b0, 32'h41, 32'h0,        2'b01, 1'b0, 32'h0,        1'b1, 1'b0, t_x);
        do_req("sw_lh_40_s",  1'b0, 32'h40, 32'h0,        2'b01, 1'b1, 32'h00007F01, 1'b0, 1'b0, t_x);
        do_req("sw_lb_41_s",  1'b0, 32'h41, 32'h0,        2'b00, 1'b1, 32'h0000007F, 1'b0, 1'b0, t_x);
        do_req("sw_sb_43",    1'b1, 32'h43, 32'h123456AB, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, t_x);
        do_req("sw_sh_41_mis",1'b1, 32'h41, 32'h0000BEEF, 2'b01, 1'b0, 32'h0,        1'b1, 1'b0, t_x);
        do_req("sw_lw11_40",  1'b0, 32'h40, 32'h0,        2'b11, 1'b0, 32'hABFF7F01, 1'b0, 1'b0, t_x);
        do_req("sw_sh_40",    1'b1, 32'h40, 32'hFFFF1234, 2'b01, 1'b0, 32'h0,        1'b0, 1'b0, t_x);
        do_req("sw_lw_40",    1'b0, 32'h40, 32'h0,        2'b10, 1'b0, 32'hABFF1234, 1'b0, 1'b0, t_x);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
